// File: rtl/risc_core.sv
// Single-cycle RISC core with a 16-bit instruction set, an internal instruction ROM and a data SRAM.
// Each clock fetches rom0.memory[pc_out], decodes it combinationally and commits all state on the next edge.

module risc_pc #(
  parameter int unsigned A_SIZE = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [A_SIZE-1:0] pc_d,
  output logic [A_SIZE-1:0] pc_out
);
  always_ff @(posedge clk) begin
    if (!rstn) pc_out <= '0;
    else       pc_out <= pc_d;
  end
endmodule

module risc_rom #(
  parameter int unsigned A_SIZE = 10,
  parameter int unsigned I_SIZE = 16
) (
  input  logic              clk,
  input  logic              load_en,
  input  logic [A_SIZE-1:0] load_addr,
  input  logic [I_SIZE-1:0] load_data,
  input  logic [A_SIZE-1:0] rd_addr,
  output logic [I_SIZE-1:0] rd_data
);
  localparam int unsigned DEPTH = 2 ** A_SIZE;

  logic [I_SIZE-1:0] memory [0:DEPTH-1];

  // Load port exists only so the array has a synthesizable writer; the core ties it off.
  always_ff @(posedge clk) begin
    if (load_en) memory[load_addr] <= load_data;
  end

  assign rd_data = memory[rd_addr];
endmodule

module risc_sram #(
  parameter int unsigned A_SIZE = 10,
  parameter int unsigned D_SIZE = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [A_SIZE-1:0] waddr,
  input  logic [D_SIZE-1:0] wdata,
  input  logic [A_SIZE-1:0] raddr,
  output logic [D_SIZE-1:0] rdata
);
  localparam int unsigned DEPTH = 2 ** A_SIZE;

  logic [D_SIZE-1:0] memory [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) memory[waddr] <= wdata;
  end

  assign rdata = memory[raddr];
endmodule

module risc_regfile #(
  parameter int unsigned D_SIZE = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [D_SIZE-1:0] wdata,
  input  logic [2:0]        ra_addr,
  output logic [D_SIZE-1:0] ra_data,
  input  logic [2:0]        rb_addr,
  output logic [D_SIZE-1:0] rb_data
);
  logic [D_SIZE-1:0] regs [0:7];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
endmodule

module risc_core #(
  parameter int unsigned D_SIZE = 32,
  parameter int unsigned A_SIZE = 10,
  parameter int unsigned I_SIZE = 16
) (
  input logic clk,
  input logic rstn
);
  localparam logic [6:0] OP_ADD  = 7'b0000001;
  localparam logic [6:0] OP_SUB  = 7'b0000010;
  localparam logic [6:0] OP_AND  = 7'b0000011;
  localparam logic [6:0] OP_OR   = 7'b0000100;
  localparam logic [6:0] OP_XOR  = 7'b0000101;
  localparam logic [6:0] OP_NXOR = 7'b0000110;
  localparam logic [6:0] OP_SHR  = 7'b0000111;
  localparam logic [6:0] OP_SRA  = 7'b0001000;
  localparam logic [6:0] OP_SHL  = 7'b0001001;
  localparam logic [4:0] OP_LOAD  = 5'b01000;
  localparam logic [4:0] OP_LOADC = 5'b01001;
  localparam logic [4:0] OP_STORE = 5'b01010;
  localparam logic [2:0] J_JMP    = 3'b000;
  localparam logic [2:0] J_JMPR   = 3'b001;
  localparam logic [2:0] J_JMPC   = 3'b010;
  localparam logic [2:0] J_JMPRC  = 3'b011;

  logic [A_SIZE-1:0] pc_out;
  logic [A_SIZE-1:0] pc_d;
  logic [A_SIZE-1:0] pc_inc;
  logic [A_SIZE-1:0] pc_rel;
  logic [A_SIZE-1:0] off_ext;
  logic [I_SIZE-1:0] instr;
  logic [2:0]        ra_addr;
  logic [2:0]        rb_addr;
  logic [D_SIZE-1:0] ra_data;
  logic [D_SIZE-1:0] rb_data;
  logic              reg_we;
  logic [2:0]        reg_waddr;
  logic [D_SIZE-1:0] reg_wdata;
  logic              sram_we;
  logic [D_SIZE-1:0] sram_rdata;
  logic [5:0]        amt;

  risc_pc #(.A_SIZE(A_SIZE)) pc0 (
    .clk    (clk),
    .rstn   (rstn),
    .pc_d   (pc_d),
    .pc_out (pc_out)
  );

  risc_rom #(.A_SIZE(A_SIZE), .I_SIZE(I_SIZE)) rom0 (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .rd_addr   (pc_out),
    .rd_data   (instr)
  );

  risc_sram #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE)) sram0 (
    .clk   (clk),
    .we    (sram_we && rstn),
    .waddr (ra_data[A_SIZE-1:0]),
    .wdata (rb_data),
    .raddr (rb_data[A_SIZE-1:0]),
    .rdata (sram_rdata)
  );

  risc_regfile #(.D_SIZE(D_SIZE)) registers0 (
    .clk     (clk),
    .rstn    (rstn),
    .we      (reg_we),
    .waddr   (reg_waddr),
    .wdata   (reg_wdata),
    .ra_addr (ra_addr),
    .ra_data (ra_data),
    .rb_addr (rb_addr),
    .rb_data (rb_data)
  );

  function automatic logic cond_met(input logic [2:0] code, input logic [D_SIZE-1:0] v);
    case (code)
      3'b000:  return v[D_SIZE-1];
      3'b001:  return !v[D_SIZE-1];
      3'b010:  return (v == '0);
      3'b011:  return (v != '0);
      default: return 1'b0;
    endcase
  endfunction

  assign amt     = instr[5:0];
  assign off_ext = {{(A_SIZE-6){instr[5]}}, instr[5:0]};
  assign pc_inc  = pc_out + A_SIZE'(1);
  assign pc_rel  = pc_out + off_ext;
  assign rb_addr = instr[2:0];

  // Port A selects src1 for ALU ops, the address register for STORE, else [8:6].
  always_comb begin
    ra_addr = instr[8:6];
    if (!instr[15]) begin
      if (instr[15:11] == OP_STORE) begin
        ra_addr = instr[10:8];
      end else if (instr[15:9] >= OP_ADD && instr[15:9] <= OP_NXOR) begin
        ra_addr = instr[5:3];
      end
    end
  end

  always_comb begin
    pc_d      = pc_inc;
    reg_we    = 1'b0;
    reg_waddr = instr[8:6];
    reg_wdata = '0;
    sram_we   = 1'b0;
    if (instr[15]) begin
      case (instr[14:12])
        J_JMP:   pc_d = rb_data[A_SIZE-1:0];
        J_JMPR:  pc_d = pc_rel;
        J_JMPC:  if (cond_met(instr[11:9], ra_data)) pc_d = rb_data[A_SIZE-1:0];
        J_JMPRC: if (cond_met(instr[11:9], ra_data)) pc_d = pc_rel;
        default: ;
      endcase
    end else begin
      case (instr[15:11])
        OP_LOAD: begin
          reg_we    = 1'b1;
          reg_waddr = instr[10:8];
          reg_wdata = sram_rdata;
        end
        OP_LOADC: begin
          reg_we    = 1'b1;
          reg_waddr = instr[10:8];
          reg_wdata = D_SIZE'(instr[7:0]);
        end
        OP_STORE: sram_we = 1'b1;
        default: begin
          reg_we = 1'b1;
          case (instr[15:9])
            OP_ADD:  reg_wdata = ra_data + rb_data;
            OP_SUB:  reg_wdata = ra_data - rb_data;
            OP_AND:  reg_wdata = ra_data & rb_data;
            OP_OR:   reg_wdata = ra_data | rb_data;
            OP_XOR:  reg_wdata = ra_data ^ rb_data;
            OP_NXOR: reg_wdata = ~(ra_data ^ rb_data);
            OP_SHR:  reg_wdata = ra_data >> amt;
            OP_SRA:  reg_wdata = $unsigned($signed(ra_data) >>> amt);
            OP_SHL:  reg_wdata = ra_data << amt;
            default: reg_we = 1'b0;
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_risc_core.sv
// Directed bench for risc_core: programs are loaded back-door into rom0, registers seeded after reset,
// and PC/register/SRAM state is checked after every executed instruction.

module tb_risc_core;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  risc_core #(.D_SIZE(32), .A_SIZE(10), .I_SIZE(16)) dut (
    .clk  (clk),
    .rstn (rstn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] e_alu(input logic [6:0] op, input int d, input int s1, input int s2);
    return {op, 3'(d), 3'(s1), 3'(s2)};
  endfunction
  function automatic logic [15:0] e_sh(input logic [6:0] op, input int r, input int a);
    return {op, 3'(r), 6'(a)};
  endfunction
  function automatic logic [15:0] e_mem(input logic [4:0] op, input int a, input int b);
    return {op, 3'(a), 5'b0, 3'(b)};
  endfunction
  function automatic logic [15:0] e_loadc(input int d, input int c);
    return {5'b01001, 3'(d), 8'(c)};
  endfunction
  function automatic logic [15:0] e_jmp(input int r);
    return {4'b1000, 9'b0, 3'(r)};
  endfunction
  function automatic logic [15:0] e_jmpr(input int off);
    return {4'b1001, 6'b0, 6'(off)};
  endfunction
  function automatic logic [15:0] e_jc(input int c, input int t, input int r);
    return {4'b1010, 3'(c), 3'(t), 3'b0, 3'(r)};
  endfunction
  function automatic logic [15:0] e_jrc(input int c, input int t, input int off);
    return {4'b1011, 3'(c), 3'(t), 6'(off)};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Enter reset and wipe the program; must be called at a negedge.
  task automatic begin_reset();
    rstn = 1'b0;
    for (int i = 0; i < 1024; i++) dut.rom0.memory[i] = 16'h0000;
  endtask

  task automatic finish_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pc();
    return 32'(dut.pc0.pc_out);
  endfunction
  function automatic logic [31:0] r(input int i);
    return dut.registers0.regs[i];
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn     = 1'b0;
    for (int i = 0; i < 1024; i++) dut.sram0.memory[i] = 32'h0;
    for (int i = 0; i < 8; i++) dut.registers0.regs[i] = 32'hA5A5_0000 + 32'(i);

    // ALU ops
    begin_reset();
    dut.rom0.memory[0] = e_alu(7'b0000001, 0, 1, 2);
    dut.rom0.memory[1] = e_alu(7'b0000010, 3, 4, 5);
    dut.rom0.memory[2] = e_alu(7'b0000101, 3, 4, 5);
    dut.rom0.memory[3] = e_alu(7'b0000110, 3, 4, 5);
    dut.rom0.memory[4] = e_alu(7'b0000001, 1, 1, 1);
    dut.rom0.memory[5] = e_alu(7'b0000100, 7, 1, 2);
    dut.rom0.memory[6] = e_alu(7'b0000011, 6, 0, 2);
    finish_reset();
    check_eq("reset_pc", pc(), 32'd0);
    for (int i = 0; i < 8; i++) check_eq($sformatf("reset_r%0d", i), r(i), 32'h0);
    dut.registers0.regs[1] = 32'd2;
    dut.registers0.regs[2] = 32'd3;
    dut.registers0.regs[4] = 32'h6666_6666;
    dut.registers0.regs[5] = 32'h7E6E_76EE;
    rstn = 1'b1;
    step(); check_eq("add_r0", r(0), 32'd5); check_eq("add_pc", pc(), 32'd1);
    step(); check_eq("sub_r3", r(3), 32'hE7F7_EF78); check_eq("sub_pc", pc(), 32'd2);
    step(); check_eq("xor_r3", r(3), 32'h1808_1088);
    step(); check_eq("nxor_r3", r(3), 32'hE7F7_EF77);
    step(); check_eq("add_self_r1", r(1), 32'd4);
    step(); check_eq("or_r7", r(7), 32'd7);
    step(); check_eq("and_r6", r(6), 32'd1); check_eq("alu_end_pc", pc(), 32'd7);

    // Shifts and undefined encodings
    begin_reset();
    dut.rom0.memory[0] = e_sh(7'b0001001, 2, 0);
    dut.rom0.memory[1] = e_sh(7'b0001001, 2, 2);
    dut.rom0.memory[2] = e_sh(7'b0000111, 2, 2);
    dut.rom0.memory[3] = e_sh(7'b0001001, 2, 40);
    dut.rom0.memory[4] = e_loadc(2, 8'h80);
    dut.rom0.memory[5] = e_sh(7'b0000111, 2, 32);
    dut.rom0.memory[6] = 16'hFFFF;
    dut.rom0.memory[7] = 16'h7800;
    dut.rom0.memory[8] = 16'h1400;
    finish_reset();
    dut.registers0.regs[2] = 32'd3;
    rstn = 1'b1;
    step(); check_eq("shl0_r2", r(2), 32'd3);
    step(); check_eq("shl2_r2", r(2), 32'd12);
    step(); check_eq("shr2_r2", r(2), 32'd3);
    step(); check_eq("shl40_r2", r(2), 32'd0);
    step(); check_eq("loadc_r2", r(2), 32'h80);
    step(); check_eq("shr32_r2", r(2), 32'd0);
    dut.registers0.regs[2] = 32'h1234_5678;
    step(); check_eq("undef1_pc", pc(), 32'd7);
    step(); check_eq("undef2_pc", pc(), 32'd8);
    step(); check_eq("undef3_pc", pc(), 32'd9); check_eq("undef_r2", r(2), 32'h1234_5678);

    // Memory and arithmetic shifts
    begin_reset();
    dut.sram0.memory[600] = 32'h8000_0000;
    dut.rom0.memory[0] = e_mem(5'b01000, 0, 6);
    dut.rom0.memory[1] = e_alu(7'b0000100, 2, 2, 0);
    dut.rom0.memory[2] = e_sh(7'b0001000, 2, 1);
    dut.rom0.memory[3] = e_sh(7'b0001000, 2, 28);
    dut.rom0.memory[4] = e_loadc(6, 200);
    dut.rom0.memory[5] = e_mem(5'b01010, 6, 2);
    dut.rom0.memory[6] = e_sh(7'b0001000, 2, 40);
    finish_reset();
    dut.registers0.regs[6] = 32'd600;
    dut.registers0.regs[2] = 32'd3;
    rstn = 1'b1;
    step(); check_eq("load_r0", r(0), 32'h8000_0000);
    step(); check_eq("or_r2", r(2), 32'h8000_0003);
    step(); check_eq("sra1_r2", r(2), 32'hC000_0001);
    step(); check_eq("sra28_r2", r(2), 32'hFFFF_FFFC);
    step(); check_eq("loadc_r6", r(6), 32'd200);
    step(); check_eq("store_mem", dut.sram0.memory[200], 32'hFFFF_FFFC);
    step(); check_eq("sra40_r2", r(2), 32'hFFFF_FFFF);
    check_eq("sram600_kept", dut.sram0.memory[600], 32'h8000_0000);

    // Absolute-jump loop followed by a relative-jump chain
    begin_reset();
    dut.rom0.memory[18]  = e_loadc(1, 18);
    dut.rom0.memory[19]  = e_jmp(7);
    dut.rom0.memory[100] = e_alu(7'b0000010, 2, 2, 0);
    dut.rom0.memory[101] = e_jc(3'b001, 2, 1);
    dut.rom0.memory[102] = e_jmpr(-32);
    dut.rom0.memory[70]  = e_jmpr(-30);
    dut.rom0.memory[40]  = e_jmpr(-20);
    finish_reset();
    dut.registers0.regs[0] = 32'd1;
    dut.registers0.regs[2] = 32'd3;
    dut.registers0.regs[1] = 32'd18;
    dut.registers0.regs[7] = 32'd100;
    rstn = 1'b1;
    for (int i = 0; i < 18; i++) step();
    check_eq("nop_run_pc", pc(), 32'd18);
    for (int i = 0; i < 4; i++) begin
      step(); check_eq($sformatf("loop%0d_loadc_pc", i), pc(), 32'd19);
      step(); check_eq($sformatf("loop%0d_jmp_pc", i), pc(), 32'd100);
      step(); check_eq($sformatf("loop%0d_r2", i), r(2), 32'(2 - i));
      step(); check_eq($sformatf("loop%0d_jnn_pc", i), pc(), (i < 3) ? 32'd18 : 32'd102);
    end
    step(); check_eq("jmpr_m32_pc", pc(), 32'd70);
    step(); check_eq("jmpr_m30_pc", pc(), 32'd40);
    step(); check_eq("jmpr_m20_pc", pc(), 32'd20);
    step(); check_eq("after_chain_pc", pc(), 32'd21);

    // Countdown with relative conditional jumps and never-taken condition codes
    begin_reset();
    dut.rom0.memory[0]   = e_loadc(3, 105);
    dut.rom0.memory[1]   = e_jmp(3);
    dut.rom0.memory[105] = e_alu(7'b0000010, 2, 2, 0);
    dut.rom0.memory[106] = e_jrc(3'b011, 2, 4);
    dut.rom0.memory[110] = e_jmpr(-5);
    dut.rom0.memory[107] = e_jrc(3'b100, 0, 10);
    dut.rom0.memory[108] = e_jrc(3'b000, 2, 5);
    dut.rom0.memory[109] = e_jc(3'b010, 2, 3);
    finish_reset();
    dut.registers0.regs[2] = 32'd3;
    dut.registers0.regs[0] = 32'd1;
    rstn = 1'b1;
    step(); check_eq("cd_loadc_pc", pc(), 32'd1);
    step(); check_eq("cd_jmp_pc", pc(), 32'd105);
    for (int k = 0; k < 3; k++) begin
      step(); check_eq($sformatf("cd%0d_r2", k), r(2), 32'(2 - k));
      step(); check_eq($sformatf("cd%0d_jnz_pc", k), pc(), (k < 2) ? 32'd110 : 32'd107);
      if (k < 2) begin
        step(); check_eq($sformatf("cd%0d_back_pc", k), pc(), 32'd105);
      end
    end
    step(); check_eq("cond100_pc", pc(), 32'd108);
    step(); check_eq("cond_n_pc", pc(), 32'd109);
    step(); check_eq("cond_z_pc", pc(), 32'd105);

    // No SRAM write during reset, PC wrap, memory retention across reset
    begin_reset();
    dut.sram0.memory[0] = 32'h0000_DEAD;
    dut.rom0.memory[0]  = e_mem(5'b01010, 0, 1);
    dut.rom0.memory[1]  = e_jmp(2);
    finish_reset();
    check_eq("reset_no_store", dut.sram0.memory[0], 32'h0000_DEAD);
    check_eq("sram_kept_reset", dut.sram0.memory[200], 32'hFFFF_FFFC);
    dut.registers0.regs[0] = 32'd5;
    dut.registers0.regs[1] = 32'h1234_5678;
    dut.registers0.regs[2] = 32'd1023;
    rstn = 1'b1;
    step(); check_eq("store5_mem", dut.sram0.memory[5], 32'h1234_5678); check_eq("store5_pc", pc(), 32'd1);
    step(); check_eq("jmp_top_pc", pc(), 32'd1023);
    step(); check_eq("wrap_pc", pc(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
